// File: rtl/counter_sched.sv
// Round-robin scheduler that time-shares one WIDTH-bit up-counter between NREQ
// requesters, running it for each granted requester's latched length.
module counter_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*WIDTH-1:0]   len_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [WIDTH-1:0]        cnt_o,
  output logic                    busy_o,
  output logic [NREQ-1:0]         done_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_owner;
  logic [WIDTH-1:0] r_len_q;
  logic [WIDTH-1:0] r_cnt;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;

  logic             w_found;
  logic [PW-1:0]    w_win;
  logic [PW-1:0]    w_idx;
  logic [PW-1:0]    w_next_ptr;
  logic [WIDTH-1:0] w_len;
  logic [NREQ-1:0]  w_win_oh;

  // Search ptr, ptr+1, ... modulo NREQ; the first pending request wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = PW'((int'(r_ptr) + i) % NREQ);
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_len = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_win == PW'(k)) w_len = len_i[k*WIDTH +: WIDTH];
    end
  end

  assign w_win_oh   = NREQ'(1) << w_win;
  assign w_next_ptr = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_len_q <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_gnt  <= '0;
          r_done <= '0;
          if (w_found) begin
            r_owner <= w_win;
            r_len_q <= w_len;
            r_gnt   <= w_win_oh;
            // A zero-length job skips the counter and completes immediately.
            if (w_len == '0) begin
              r_state <= S_DONE;
              r_done  <= w_win_oh;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!req_i[r_owner]) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_ptr   <= w_next_ptr;
          end else if (r_cnt == r_len_q - 1'b1) begin
            r_state <= S_DONE;
            r_done  <= r_gnt;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_done  <= '0;
          r_cnt   <= '0;
          r_ptr   <= w_next_ptr;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt_o  = r_gnt;
  assign done_o = r_done;
  assign cnt_o  = r_cnt;
  assign busy_o = (r_state != S_IDLE);

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched: directed scenarios followed by random
// jobs, checked against a job-level model of grant order and run timing.
module tb_counter_sched;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_i;
  logic [NREQ*WIDTH-1:0] len_i;
  logic [NREQ-1:0]       gnt_o;
  logic [WIDTH-1:0]      cnt_o;
  logic                  busy_o;
  logic [NREQ-1:0]       done_o;

  int n_checks;
  int n_fail;
  int cyc;
  int last_done;
  int m_ptr;
  int m_len [NREQ];

  counter_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk    (clk),
    .reset  (reset),
    .req_i  (req_i),
    .len_i  (len_i),
    .gnt_o  (gnt_o),
    .cnt_o  (cnt_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pack_len();
    for (int k = 0; k < NREQ; k++) len_i[k*WIDTH +: WIDTH] = WIDTH'(m_len[k]);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gnt"},  32'(gnt_o),  32'd0);
    check({tag, "_cnt"},  32'(cnt_o),  32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
  endtask

  function automatic int winner(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // Called on the first granted cycle. A job of length L is granted for L+1
  // cycles; the counter shows 0..L-1 then holds, and done pulses last. If ab
  // lies in 0..L-1 the request drops on that cycle and the job is abandoned.
  // Ends on the mandatory idle cycle that follows.
  task automatic expect_job(input int k, input int L, input bit drop,
                            input bit scramble, input int ab);
    logic [NREQ-1:0] oh;
    int exp_cnt;
    oh = NREQ'(1) << k;
    for (int c = 0; c <= L; c++) begin
      exp_cnt = (L == 0) ? 0 : ((c < L) ? c : L - 1);
      check("job_gnt",  32'(gnt_o),  32'(oh));
      check("job_busy", 32'(busy_o), 32'd1);
      check("job_cnt",  32'(cnt_o),  32'(exp_cnt));
      check("job_done", 32'(done_o), (c == L) ? 32'(oh) : 32'd0);
      if (c == L) last_done = cyc;
      if (scramble && c == 0) begin
        for (int j = 0; j < NREQ; j++) len_i[j*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
      end
      if (c == ab && c < L) begin
        req_i[k] = 1'b0;
        tick();
        break;
      end
      if (c == L && drop) req_i[k] = 1'b0;
      tick();
    end
    m_ptr = (k + 1) % NREQ;
    check_idle("after_job");
  endtask

  initial begin
    int w;
    int prev_done;
    n_checks = 0;
    n_fail   = 0;
    m_ptr    = 0;
    last_done = 0;
    for (int k = 0; k < NREQ; k++) m_len[k] = k + 1;
    pack_len();
    reset = 1'b0;
    req_i = '1;

    // Reset held three cycles with every request pending.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("reset");
    end
    reset = 1'b1;
    tick();
    m_ptr = 0;
    check("first_grant", 32'(gnt_o), 32'h1);
    req_i = 4'b0001;
    expect_job(0, m_len[0], 1'b1, 1'b0, -1);

    // Single run on requester 2, length 5.
    m_len[2] = 5;
    pack_len();
    req_i = 4'b0100;
    w = winner(req_i, m_ptr);
    tick();
    expect_job(w, 5, 1'b1, 1'b0, -1);
    check("single_busy_low", 32'(busy_o), 32'd0);

    // Round-robin from a fresh pointer: order 0,1,2,3,0, done 4 cycles apart.
    reset = 1'b0;
    tick();
    check_idle("rr_reset");
    m_ptr = 0;
    reset = 1'b1;
    for (int k = 0; k < NREQ; k++) m_len[k] = 2;
    pack_len();
    req_i = '1;
    prev_done = 0;
    for (int j = 0; j < 5; j++) begin
      w = winner(req_i, m_ptr);
      check("rr_order", 32'(w), 32'(j % NREQ));
      tick();
      expect_job(w, 2, 1'b0, 1'b0, -1);
      if (j > 0) check("rr_done_spacing", 32'(last_done - prev_done), 32'd4);
      prev_done = last_done;
    end
    req_i = '0;
    tick();
    check_idle("rr_drained");

    // Zero length on requester 1: grant and done in one cycle.
    m_len[1] = 0;
    pack_len();
    req_i = 4'b0010;
    w = winner(req_i, m_ptr);
    check("zero_winner", 32'(w), 32'd1);
    tick();
    expect_job(w, 0, 1'b1, 1'b0, -1);

    // Abandon: requester 3 length 10 drops at cnt 4; requester 0 pending.
    m_len[3] = 10;
    m_len[0] = 3;
    pack_len();
    req_i = 4'b1001;
    w = winner(req_i, m_ptr);
    check("abandon_winner", 32'(w), 32'd3);
    tick();
    expect_job(w, 10, 1'b1, 1'b0, 4);
    w = winner(req_i, m_ptr);
    check("abandon_next", 32'(w), 32'd0);
    tick();
    expect_job(w, 3, 1'b1, 1'b0, -1);

    // Reset at cnt 7 of a length-255 run on requester 2.
    m_len[2] = 255;
    pack_len();
    req_i = 4'b0100;
    tick();
    for (int c = 0; c <= 7; c++) begin
      check("long_gnt", 32'(gnt_o), 32'h4);
      check("long_cnt", 32'(cnt_o), 32'(c));
      if (c == 7) reset = 1'b0;
      tick();
    end
    check_idle("midrun_reset");
    m_ptr = 0;
    reset = 1'b1;
    m_len[2] = 3;
    m_len[3] = 1;
    pack_len();
    req_i = 4'b1100;
    w = winner(req_i, m_ptr);
    tick();
    expect_job(w, m_len[w], 1'b1, 1'b0, -1);
    w = winner(req_i, m_ptr);
    check("post_reset_second", 32'(w), 32'd3);
    tick();
    expect_job(w, m_len[w], 1'b1, 1'b0, -1);

    // Random jobs: pending losers stay high, lengths scrambled after grant.
    for (int it = 0; it < 30; it++) begin
      int ab;
      req_i = req_i | NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if (req_i == '0) req_i = NREQ'(1) << $urandom_range(0, NREQ - 1);
      for (int k = 0; k < NREQ; k++) m_len[k] = $urandom_range(0, 9);
      pack_len();
      w = winner(req_i, m_ptr);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : -1;
      tick();
      expect_job(w, m_len[w], 1'b1, 1'b1, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
